// File: rtl/vga_timing_core.sv
// vga_timing_core
//   Parametrised VGA raster timing generator. A clock-enable divider produces
//   the pixel tick; x/y counters walk the raster on each tick; hs/vs/blank_n are
//   decoded from x/y and delayed PIPE_DLY ticks to line up with downstream colour
//   logic. Event pulses and a wrapping frame counter are registered with x/y.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-low
//   run          1 = raster advances, 0 = everything holds
//   pix_en       one-clk pixel tick strobe
//   x, y         current column / line
//   hs, vs       syncs at HS_POL / VS_POL level when asserted, delayed PIPE_DLY ticks
//   blank_n      1 inside the active area, delayed PIPE_DLY ticks
//   sync_n       composite sync for the DAC, tied 1
//   active       undelayed active-area flag for x/y
//   line_start   one-clk pulse when x becomes 0
//   frame_start  one-clk pulse when (x,y) becomes (0,0)
//   vblank_start one-clk pulse when (x,y) becomes (0,V_VA)
//   frame_cnt    completed frames, wraps

module vga_timing_core #(
    parameter int CW       = 10,
    parameter int H_VA     = 640,
    parameter int H_FP     = 16,
    parameter int H_SP     = 96,
    parameter int H_BP     = 48,
    parameter int V_VA     = 480,
    parameter int V_FP     = 10,
    parameter int V_SP     = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int PIPE_DLY = 2,
    parameter int FC_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            pix_en,
    output logic [CW-1:0]   x,
    output logic [CW-1:0]   y,
    output logic            hs,
    output logic            vs,
    output logic            blank_n,
    output logic            sync_n,
    output logic            active,
    output logic            line_start,
    output logic            frame_start,
    output logic            vblank_start,
    output logic [FC_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_VA + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_VA + V_FP + V_SP + V_BP;

    // Decode bounds are held one bit wider than x/y so a bound equal to
    // 2**CW still compares correctly.
    localparam logic [CW:0] H_VA_C   = (CW+1)'(H_VA);
    localparam logic [CW:0] HS_BEG_C = (CW+1)'(H_VA + H_FP);
    localparam logic [CW:0] HS_END_C = (CW+1)'(H_VA + H_FP + H_SP);
    localparam logic [CW:0] V_VA_C   = (CW+1)'(V_VA);
    localparam logic [CW:0] VS_BEG_C = (CW+1)'(V_VA + V_FP);
    localparam logic [CW:0] VS_END_C = (CW+1)'(V_VA + V_FP + V_SP);
    localparam logic [CW:0] X_LAST_C = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] Y_LAST_C = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] Y_VBL_C  = (CW+1)'(V_VA - 1);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic       HS_ON    = (HS_POL != 0);
    localparam logic       VS_ON    = (VS_POL != 0);

    generate
        if (H_TOTAL > 2**CW) begin : g_chk_h
            $error("vga_timing_core: H_TOTAL does not fit in CW bits");
        end
        if (V_TOTAL > 2**CW) begin : g_chk_v
            $error("vga_timing_core: V_TOTAL does not fit in CW bits");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_chk_div
            $error("vga_timing_core: CLK_DIV must be 1..16");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_chk_pipe
            $error("vga_timing_core: PIPE_DLY must be 0..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel-clock-enable divider. A tick earned while run=1 is always
    // delivered, even if run drops in the cycle pix_en is high, so toggling
    // run can never lose or repeat a tick.
    // ------------------------------------------------------------------
    logic [3:0] div;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else if (run) begin
            pix_en <= (div == DIV_LAST);
            div    <= (div == DIV_LAST) ? '0 : div + 4'd1;
        end else begin
            pix_en <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters and event pulses
    // ------------------------------------------------------------------
    logic [CW:0] x_ext;
    logic [CW:0] y_ext;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};

    always_ff @(posedge clk) begin
        if (!rst) begin
            x            <= '0;
            y            <= '0;
            frame_cnt    <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pix_en) begin
                if (x_ext == X_LAST_C) begin
                    x          <= '0;
                    line_start <= 1'b1;
                    if (y_ext == Y_LAST_C) begin
                        y           <= '0;
                        frame_cnt   <= frame_cnt + FC_W'(1);
                        frame_start <= 1'b1;
                    end else begin
                        y <= y + CW'(1);
                        if (y_ext == Y_VBL_C) begin
                            vblank_start <= 1'b1;
                        end
                    end
                end else begin
                    x <= x + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Undelayed decode (all active-high internally)
    // ------------------------------------------------------------------
    logic hs_raw;
    logic vs_raw;
    logic act_raw;

    always_comb begin
        act_raw = (x_ext < H_VA_C) && (y_ext < V_VA_C);
        hs_raw  = (x_ext >= HS_BEG_C) && (x_ext < HS_END_C);
        vs_raw  = (y_ext >= VS_BEG_C) && (y_ext < VS_END_C);
    end

    assign active = act_raw;

    // ------------------------------------------------------------------
    // Sync/blank alignment pipeline, advancing only on pixel ticks.
    // Reset fills it with deasserted syncs and blanking.
    // ------------------------------------------------------------------
    logic hs_d;
    logic vs_d;
    logic bl_d;

    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign hs_d = hs_raw;
            assign vs_d = vs_raw;
            assign bl_d = act_raw;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_p;
            logic [PIPE_DLY-1:0] vs_p;
            logic [PIPE_DLY-1:0] bl_p;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    hs_p <= '0;
                    vs_p <= '0;
                    bl_p <= '0;
                end else if (pix_en) begin
                    hs_p <= (hs_p << 1) | PIPE_DLY'(hs_raw);
                    vs_p <= (vs_p << 1) | PIPE_DLY'(vs_raw);
                    bl_p <= (bl_p << 1) | PIPE_DLY'(act_raw);
                end
            end

            assign hs_d = hs_p[PIPE_DLY-1];
            assign vs_d = vs_p[PIPE_DLY-1];
            assign bl_d = bl_p[PIPE_DLY-1];
        end
    endgenerate

    assign hs      = ~(hs_d ^ HS_ON);
    assign vs      = ~(vs_d ^ VS_ON);
    assign blank_n = bl_d;
    assign sync_n  = 1'b1;

endmodule
